// File: rtl/conv_cfg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conv_cfg_pkg : config word map, ctrl bits and FSM states             |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package conv_cfg_pkg;

   // ctrl word (word 0) enable bits
   localparam int WORD_CTRL       = 0;
   localparam int EN_MAC          = 0;
   localparam int EN_PACK         = 1;

   localparam int WORD_CALC       = 1;
   localparam int CALFMT_LSB      = 0;
   localparam int CALFMT_W        = 4;
   localparam int STRIDE_H_LSB    = 8;
   localparam int STRIDE_W_LSB    = 12;
   localparam int STRIDE_W        = 4;
   localparam int CAL_ROUND_LSB   = 16;
   localparam int CAL_ROUND_W     = 5;

   localparam int WORD_GROUP      = 2;
   localparam int GROUP_N_LSB     = 0;
   localparam int GROUP_CH_LSB    = 16;
   localparam int GROUP_W         = 16;

   localparam int WORD_FMAP_BASE  = 3;
   localparam int WORD_KERN_BASE  = 4;
   localparam int WORD_FMAP_SHAPE = 5;
   localparam int FMAP_H_LSB      = 0;
   localparam int FMAP_W_LSB      = 16;
   localparam int WORD_FMAP_CH    = 6;
   localparam int WORD_KERN_SHAPE = 7;
   localparam int KERN_H_LSB      = 0;
   localparam int KERN_W_LSB      = 8;

   localparam int WORD_PAD        = 8;
   localparam int PAD_TOP_LSB     = 0;
   localparam int PAD_BOT_LSB     = 4;
   localparam int PAD_LEFT_LSB    = 8;
   localparam int PAD_RIGHT_LSB   = 12;
   localparam int WORD_DIL        = 9;
   localparam int DIL_H_LSB       = 0;
   localparam int DIL_W_LSB       = 4;

   localparam int WORD_BUF_BANK   = 10;
   localparam int BUF_BANK_N_LSB  = 0;
   localparam int BUF_ROW_N_LSB   = 8;
   localparam int WORD_BUF_GROUP  = 11;
   localparam int WORD_MID_SIZE   = 12;
   localparam int WORD_MID_BASE   = 13;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      ARM  = 2'd2,
      RUN  = 2'd3
   } cfg_state_e;

endpackage
`default_nettype wire

// File: rtl/conv_cfg_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conv_cfg_fifo : wide-entry register FIFO, push/pop/flush, push-on-full|
// | when popping. rev 1.0                                                |
// +----------------------------------------------------------------------+
module conv_cfg_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full
);
   localparam int              PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int              CW      = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
   localparam logic [PTR_W-1:0] LAST   = PTR_W'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wptr, rptr;
   logic             push_acc, pop_acc;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST) ? '0 : p + PTR_W'(1);
   endfunction

   assign full     = (count == DEPTH_C);
   assign pop_acc  = pop && (count != '0);
   // a pop in the same cycle frees the slot the push needs
   assign push_acc = push && !flush && (!full || pop_acc);
   assign head     = mem[rptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push_acc) begin
         mem[wptr] <= din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push_acc) wptr <= ptr_inc(wptr);
         if (pop_acc)  rptr <= ptr_inc(rptr);
         if (push_acc && !pop_acc)      count <= count + CW'(1);
         else if (!push_acc && pop_acc) count <= count - CW'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/conv_cfg_layer_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conv_cfg_layer_queue : staged, queued per-layer config with start/done|
// | sequencing for the convolution core. rev 1.0                         |
// +----------------------------------------------------------------------+
module conv_cfg_layer_queue
   import conv_cfg_pkg::*;
#(
   parameter int CFG_WORD_N  = 24,
   parameter int QUEUE_DEPTH = 2,
   parameter int CNT_W       = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             wr_en,
   input  logic [$clog2(CFG_WORD_N)-1:0]    wr_addr,
   input  logic [31:0]                      wr_data,
   input  logic                             cfg_push,
   input  logic                             cfg_flush,
   input  logic                             abort,
   input  logic                             layer_done,
   output logic                             push_rdy,
   output logic                             wr_err,
   output logic                             push_err,
   output logic                             layer_start,
   output logic [CFG_WORD_N*32-1:0]         active_cfg,
   output logic                             en_mac_array,
   output logic                             en_packer,
   output logic                             busy,
   output logic [$clog2(QUEUE_DEPTH):0]     q_count,
   output logic [CNT_W-1:0]                 layers_done
);
   localparam int              ADDR_W   = $clog2(CFG_WORD_N);
   localparam int              BANK_W   = CFG_WORD_N * 32;
   localparam logic [ADDR_W:0] WORD_N_C = (ADDR_W + 1)'(CFG_WORD_N);

   logic [31:0]       staging     [CFG_WORD_N];
   logic [31:0]       staging_nxt [CFG_WORD_N];
   logic [BANK_W-1:0] staging_flat, fifo_head;
   logic              fifo_full, pop, addr_oob, run_like;
   cfg_state_e        state, state_nxt;

   assign addr_oob = ({1'b0, wr_addr} >= WORD_N_C);

   always_comb begin
      for (int i = 0; i < CFG_WORD_N; i++)
         staging_nxt[i] = (wr_en && (wr_addr == ADDR_W'(i))) ? wr_data : staging[i];
   end

   // queue snapshots the post-write staging so a same-cycle write is captured
   for (genvar g = 0; g < CFG_WORD_N; g++) begin : g_flat
      assign staging_flat[32*g +: 32] = staging_nxt[g];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CFG_WORD_N; i++) staging[i] <= '0;
      end else begin
         for (int i = 0; i < CFG_WORD_N; i++) staging[i] <= staging_nxt[i];
      end
   end

   conv_cfg_fifo #(
      .WIDTH (BANK_W),
      .DEPTH (QUEUE_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (cfg_push),
      .pop   (pop),
      .flush (cfg_flush),
      .din   (staging_flat),
      .head  (fifo_head),
      .count (q_count),
      .full  (fifo_full)
   );

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         IDLE: if (q_count != '0) state_nxt = LOAD;
         LOAD: begin
            // a flush in the preceding IDLE cycle can leave nothing to pop
            if (q_count != '0) begin
               pop       = 1'b1;
               state_nxt = ARM;
            end else begin
               state_nxt = IDLE;
            end
         end
         ARM:  state_nxt = abort ? IDLE : RUN;
         RUN:  if (abort || layer_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         active_cfg  <= '0;
         layers_done <= '0;
         wr_err      <= 1'b0;
         push_err    <= 1'b0;
      end else begin
         state    <= state_nxt;
         wr_err   <= wr_en && addr_oob;
         push_err <= cfg_push && !cfg_flush && fifo_full && !pop;
         if (pop) active_cfg <= fifo_head;
         if (state == RUN && layer_done && !abort)
            layers_done <= layers_done + CNT_W'(1);
      end
   end

   assign run_like     = (state == ARM) || (state == RUN);
   assign push_rdy     = !fifo_full;
   assign layer_start  = (state == ARM);
   assign busy         = (state != IDLE);
   assign en_mac_array = run_like && active_cfg[32*WORD_CTRL + EN_MAC];
   assign en_packer    = run_like && active_cfg[32*WORD_CTRL + EN_PACK];

endmodule
`default_nettype wire

// File: tb/tb_conv_cfg_layer_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_conv_cfg_layer_queue : vector table, corner sequences and random  |
// | traffic against a queue-level reference model. rev 1.0               |
// +----------------------------------------------------------------------+
module tb_conv_cfg_layer_queue;
   localparam int N  = 24;
   localparam int QD = 2;
   localparam int CW = 4;
   localparam int AW = 5;
   localparam int BW = N * 32;
   localparam int P_IDLE = 0, P_LOAD = 1, P_ARM = 2, P_RUN = 3;

   logic          clk = 1'b0;
   logic          rst, wr_en, cfg_push, cfg_flush, abort, layer_done;
   logic [AW-1:0] wr_addr;
   logic [31:0]   wr_data;
   logic          push_rdy, wr_err, push_err, layer_start, en_mac_array, en_packer, busy;
   logic [BW-1:0] active_cfg;
   logic [1:0]    q_count;
   logic [CW-1:0] layers_done;

   always #5 clk = ~clk;

   conv_cfg_layer_queue #(.CFG_WORD_N(N), .QUEUE_DEPTH(QD), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .cfg_push(cfg_push), .cfg_flush(cfg_flush), .abort(abort), .layer_done(layer_done),
      .push_rdy(push_rdy), .wr_err(wr_err), .push_err(push_err), .layer_start(layer_start),
      .active_cfg(active_cfg), .en_mac_array(en_mac_array), .en_packer(en_packer),
      .busy(busy), .q_count(q_count), .layers_done(layers_done)
   );

   int checks = 0;
   int errors = 0;

   // reference model: staging array, queue of whole layers, phase of the layer
   logic [31:0]   m_stg [N];
   logic [BW-1:0] m_q [$];
   logic [BW-1:0] m_act;
   int            m_phase, m_ld;
   logic          m_werr, m_perr;

   typedef struct {
      logic [3:0]    ctl;   // {push, flush, abort, done}
      logic          we;
      logic [AW-1:0] a;
      logic [31:0]   d;
      int            qc;
      logic [2:0]    sbe;   // {layer_start, busy, en_mac_array}
      int            ld;
      logic [1:0]    errs;  // {wr_err, push_err}
   } vec_t;
   vec_t vt [16];

   task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_stg[i] = '0;
      m_q.delete();
      m_act = '0; m_phase = P_IDLE; m_ld = 0; m_werr = 1'b0; m_perr = 1'b0;
   endtask

   task automatic model_edge();
      int            pre;
      bit            popped;
      logic [BW-1:0] snap;
      pre    = m_q.size();
      m_werr = wr_en && (int'(wr_addr) >= N);
      if (wr_en && int'(wr_addr) < N) m_stg[wr_addr] = wr_data;
      for (int i = 0; i < N; i++) snap[32*i +: 32] = m_stg[i];
      popped = (m_phase == P_LOAD) && (pre > 0);
      m_perr = 1'b0;
      if (popped) m_act = m_q.pop_front();
      if (cfg_flush) m_q.delete();
      else if (cfg_push) begin
         if (pre < QD || popped) m_q.push_back(snap);
         else m_perr = 1'b1;
      end
      case (m_phase)
         P_IDLE: if (pre > 0) m_phase = P_LOAD;
         P_LOAD: m_phase = (pre > 0) ? P_ARM : P_IDLE;
         P_ARM:  m_phase = abort ? P_IDLE : P_RUN;
         default: begin
            if (abort) m_phase = P_IDLE;
            else if (layer_done) begin
               m_phase = P_IDLE;
               m_ld    = (m_ld + 1) % (1 << CW);
            end
         end
      endcase
   endtask

   task automatic compare();
      bit on;
      on = (m_phase == P_ARM) || (m_phase == P_RUN);
      chk("push_rdy",    BW'(push_rdy),     BW'(m_q.size() < QD));
      chk("q_count",     BW'(q_count),      BW'(m_q.size()));
      chk("layer_start", BW'(layer_start),  BW'(m_phase == P_ARM));
      chk("busy",        BW'(busy),         BW'(m_phase != P_IDLE));
      chk("en_mac",      BW'(en_mac_array), BW'(on && m_act[0]));
      chk("en_packer",   BW'(en_packer),    BW'(on && m_act[1]));
      chk("active_cfg",  active_cfg,        m_act);
      chk("layers_done", BW'(layers_done),  BW'(m_ld));
      chk("wr_err",      BW'(wr_err),       BW'(m_werr));
      chk("push_err",    BW'(push_err),     BW'(m_perr));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      compare();
   endtask

   task automatic cyc(input logic we, input logic [AW-1:0] a, input logic [31:0] d,
                      input logic p, input logic f, input logic ab, input logic dn);
      wr_en = we; wr_addr = a; wr_data = d;
      cfg_push = p; cfg_flush = f; abort = ab; layer_done = dn;
      tick();
   endtask

   task automatic idle();
      cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic async_reset();
      wr_en = 0; cfg_push = 0; cfg_flush = 0; abort = 0; layer_done = 0;
      #2 rst = 1'b1;
      model_reset();
      #1 compare();
      @(posedge clk);
      #1 compare();
      #2 rst = 1'b0;
   endtask

   initial begin
      vt[0]  = '{4'b1000, 1'b0, 5'd0,  32'h0,         1, 3'b000, 0, 2'b00};
      vt[1]  = '{4'b0000, 1'b0, 5'd0,  32'h0,         1, 3'b010, 0, 2'b00};
      vt[2]  = '{4'b0000, 1'b0, 5'd0,  32'h0,         0, 3'b111, 0, 2'b00};
      vt[3]  = '{4'b1000, 1'b0, 5'd0,  32'h0,         1, 3'b011, 0, 2'b00};
      vt[4]  = '{4'b1000, 1'b0, 5'd0,  32'h0,         2, 3'b011, 0, 2'b00};
      vt[5]  = '{4'b1000, 1'b0, 5'd0,  32'h0,         2, 3'b011, 0, 2'b01};
      vt[6]  = '{4'b0000, 1'b1, 5'd24, 32'hFFFF_FFFF, 2, 3'b011, 0, 2'b10};
      vt[7]  = '{4'b0001, 1'b0, 5'd0,  32'h0,         2, 3'b000, 1, 2'b00};
      vt[8]  = '{4'b0000, 1'b0, 5'd0,  32'h0,         2, 3'b010, 1, 2'b00};
      vt[9]  = '{4'b1000, 1'b0, 5'd0,  32'h0,         2, 3'b111, 1, 2'b00};
      vt[10] = '{4'b0011, 1'b0, 5'd0,  32'h0,         2, 3'b000, 1, 2'b00};
      vt[11] = '{4'b0000, 1'b0, 5'd0,  32'h0,         2, 3'b010, 1, 2'b00};
      vt[12] = '{4'b0100, 1'b0, 5'd0,  32'h0,         0, 3'b111, 1, 2'b00};
      vt[13] = '{4'b0000, 1'b0, 5'd0,  32'h0,         0, 3'b011, 1, 2'b00};
      vt[14] = '{4'b0011, 1'b0, 5'd0,  32'h0,         0, 3'b000, 1, 2'b00};
      vt[15] = '{4'b0000, 1'b0, 5'd0,  32'h0,         0, 3'b000, 1, 2'b00};

      rst = 1'b1;
      wr_en = 0; wr_addr = '0; wr_data = '0;
      cfg_push = 0; cfg_flush = 0; abort = 0; layer_done = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 compare();
      #2 rst = 1'b0;

      for (int i = 0; i < N; i++)
         cyc(1'b1, AW'(i), (i == 0) ? 32'h3 : (i == 5) ? 32'hDEAD_0001 : 32'h1000_0000 + i,
             1'b0, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 16; i++) begin
         cyc(vt[i].we, vt[i].a, vt[i].d, vt[i].ctl[3], vt[i].ctl[2], vt[i].ctl[1], vt[i].ctl[0]);
         chk($sformatf("vec%0d q_count", i), BW'(q_count), BW'(vt[i].qc));
         chk($sformatf("vec%0d start_busy_en", i), BW'({layer_start, busy, en_mac_array}),
             BW'(vt[i].sbe));
         chk($sformatf("vec%0d layers_done", i), BW'(layers_done), BW'(vt[i].ld));
         chk($sformatf("vec%0d wr_push_err", i), BW'({wr_err, push_err}), BW'(vt[i].errs));
      end
      chk("word0", BW'(active_cfg[31:0]), BW'(32'h3));
      chk("word5", BW'(active_cfg[5*32 +: 32]), BW'(32'hDEAD_0001));

      // same-cycle write is captured by the push; flush during RUN leaves the layer running
      cyc(1'b1, 5'd5, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b0);
      idle();
      idle();
      chk("bypass word5", BW'(active_cfg[5*32 +: 32]), BW'(32'h1234_5678));
      idle();
      cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("pre-flush q_count", BW'(q_count), BW'(2));
      cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("flush q_count", BW'(q_count), BW'(0));
      chk("flush busy", BW'(busy), BW'(1));
      cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle();
      chk("flush stays idle", BW'(busy), BW'(0));
      chk("flush layers_done", BW'(layers_done), BW'(2));
      chk("flush retains word5", BW'(active_cfg[5*32 +: 32]), BW'(32'h1234_5678));

      for (int c = 0; c < 2000; c++)
         cyc($urandom_range(0, 99) < 30, AW'($urandom_range(0, 31)), $urandom,
             $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 4,
             $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 20);

      async_reset();
      for (int l = 0; l < 16; l++) begin
         cyc(1'b1, 5'd0, 32'(l), 1'b1, 1'b0, 1'b0, 1'b0);
         idle();
         idle();
         idle();
         cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
         if (l == 14) chk("wrap pre", BW'(layers_done), BW'(15));
      end
      chk("wrap zero", BW'(layers_done), BW'(0));
      chk("wrap last word0", BW'(active_cfg[31:0]), BW'(32'd15));

      cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle();
      idle();
      idle();
      cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("pre-reset busy", BW'(busy), BW'(1));
      #2 rst = 1'b1;
      model_reset();
      #1;
      chk("rst push_rdy", BW'(push_rdy), BW'(1));
      chk("rst busy", BW'(busy), BW'(0));
      chk("rst q_count", BW'(q_count), BW'(0));
      chk("rst layers_done", BW'(layers_done), BW'(0));
      chk("rst active_cfg", active_cfg, '0);
      chk("rst enables", BW'({en_mac_array, en_packer, layer_start}), BW'(0));
      compare();
      @(posedge clk);
      #3 rst = 1'b0;
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/conv_cfg_layer_queue.md
Name: conv_cfg_layer_queue

Overview:
- Runtime-configuration front end for the generic convolution engine; replaces the static, bench-driven parameter bundle with a register-written, multi-layer queued configuration.
- Host writes config words into a staging bank, then pushes them as one layer into a QUEUE_DEPTH-entry queue.
- A control FSM pops layers one at a time into an active bank, which drives the MAC array, packer, buffers and address generators.
- The active bank is held stable for the whole layer and enables are sequenced around a start/done handshake with the compute core.

Parameters:
CFG_WORD_N, 24, number of 32-bit config words per layer (calc, group, fmap, kernel, buffer fields packed per package map)
QUEUE_DEPTH, 2, layers that can be queued ahead of the running one (power of 2, >=1)
CNT_W, 16, width of completed-layer counter

Ports:
clk  in  1  sole clock
rst  in  1  asynchronous, active-high reset
wr_en  in  1  staging word write strobe
wr_addr  in  $clog2(CFG_WORD_N)  staging word index
wr_data  in  32  staging word data
cfg_push  in  1  pulse: snapshot staging bank into queue as one layer
cfg_flush  in  1  pulse: discard all queued (not active) layers
abort  in  1  pulse: terminate the running layer
layer_done  in  1  pulse from compute core: active layer complete
push_rdy  out  1  queue not full
wr_err  out  1  one-cycle pulse: wr_addr >= CFG_WORD_N
push_err  out  1  one-cycle pulse: push rejected (full)
layer_start  out  1  one-cycle pulse: active bank valid, core may start
active_cfg  out  CFG_WORD_N*32  active bank, word i at bits [32i+31:32i]
en_mac_array  out  1  word0[0] of active bank, gated by ARM/RUN
en_packer  out  1  word0[1] of active bank, gated by ARM/RUN
busy  out  1  state != IDLE
q_count  out  $clog2(QUEUE_DEPTH)+1  queued layers
layers_done  out  CNT_W  completed layers, wraps

Behaviour:
- Reset (async, rst=1): staging, queue, active_cfg, and all counters cleared to 0. All outputs 0 except push_rdy=1. FSM to IDLE. Reset mid-layer drops everything; no done count.
- Staging: wr_en with in-range address writes the word at the edge. An out-of-range address leaves staging unchanged and pulses wr_err in the next cycle. Staging is never cleared by push.
- Push: on a cfg_push edge with the queue not full, the entry at the write pointer takes staging, including a wr_en to staging in the same cycle (write-first bypass); q_count+1. If the queue is full and no pop occurs in the same cycle, the push is dropped and push_err pulses next cycle. Push while full with a simultaneous pop (LOAD) is accepted; q_count is unchanged.
- Flush: clears pointers and q_count. It does not affect the active bank or the FSM. Flush with push in the same cycle: flush wins, push silently dropped (no push_err). Flush in the LOAD cycle: the pop completes from the pre-flush head.
- FSM:
  - IDLE: if q_count>0 -> LOAD.
  - LOAD: active_cfg <= head entry, pop (read pointer+1, q_count-1) -> ARM.
  - ARM: layer_start=1 for this single cycle; enables asserted -> RUN.
  - RUN: enables held. layer_done -> IDLE, layers_done+1 (wrap at 2^CNT_W). abort -> IDLE, no increment.
- abort in ARM -> IDLE. abort has priority over layer_done in the same cycle. abort/layer_done in IDLE or LOAD are ignored.
- Latency: push at edge t into an empty queue with IDLE gives LOAD in cycle t+1, active_cfg updated and layer_start high in cycle t+2, RUN from t+3.
- Back-to-back: the layer after done gets its layer_start 3 cycles after the done edge (IDLE, LOAD, ARM). active_cfg changes only at LOAD edges.
- Enables drop to 0 in the cycle after leaving RUN/ARM. active_cfg is retained after the layer ends.
- Pointers are $clog2(QUEUE_DEPTH) bits and wrap naturally. Full is q_count==QUEUE_DEPTH; push_rdy = !full, combinational from registered q_count.

Decomposition:
- Package conv_cfg_pkg holds:
  - word-index and bit-position localparams for every config field (calfmt, strides, cal_round, group fields, fmap/kernel base addresses and shapes, padding, dilation, buffer bank/row/group counts, mid-result sizing);
  - the ctrl bit indices (EN_MAC=0, EN_PACK=1);
  - the FSM state enum (IDLE, LOAD, ARM, RUN).
- One sub-module, conv_cfg_fifo: parametrised wide-entry register FIFO with push/pop/flush, count, and simultaneous push/pop when full.

Test Plan:
- Write words 0..23 (word0=0x3, word5=0xDEAD_0001), push → q_count=1, layer_start at t+2, active word5=0xDEAD_0001, en_mac_array=en_packer=1 from t+2; layer_done → layers_done=1, enables 0 next cycle.
- Push 3 layers during RUN with QUEUE_DEPTH=2 → third push_err=1, q_count=2, push_rdy=0; after done, LOAD pops and a same-cycle push is accepted, q_count stays 2.
- wr_addr=24 with wr_data=0xFFFFFFFF → wr_err pulse, staging unchanged, next pushed layer carries prior values.
- Queue 2 layers, assert cfg_flush during RUN, then layer_done → q_count=0, FSM stays IDLE, active_cfg retains the running layer.
- abort and layer_done in the same RUN cycle → IDLE, layers_done unchanged; assert rst mid-RUN → all outputs 0, push_rdy=1, layers_done=0.
- Wrap check with CNT_W=4: 16 layers complete → layers_done back to 0; pointers wrap correctly across 5 push/pop cycles with QUEUE_DEPTH=2.
